// File: rtl/mux2_arb.sv
// Two-requester round-robin arbiter feeding a single registered valid/ready output slot.
// One transfer per cycle; the output register refills in the same cycle it drains.
module mux2_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sel_q, out_sel_d;
    logic             last_q, last_d;

    logic             load_en;
    logic             gnt_any;
    logic             gnt_idx;
    logic             accept;
    logic [WIDTH-1:0] gnt_data;

    // The output slot can take new data when empty or when it empties this cycle.
    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_idx = 1'b0;
        unique case ({req1_valid, req0_valid})
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = !last_q;
            default: gnt_idx = 1'b0;
        endcase
    end

    // Readies depend only on valids, priority and the output slot, never on payload.
    assign req0_ready = !rst && load_en && gnt_any && !gnt_idx;
    assign req1_ready = !rst && load_en && gnt_any && gnt_idx;
    assign accept     = req0_ready | req1_ready;
    assign gnt_data   = gnt_idx ? req1_data : req0_data;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_sel_d   = gnt_idx;
            last_d      = gnt_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // last resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_arb.sv
// Directed bench for mux2_arb: expected payloads are queued at acceptance time and
// checked by an independent monitor when the output drains.
module tb_mux2_arb;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_data = '0;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready = 1'b0;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    mux2_arb #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a drain happens at the next rising edge when out_valid && out_ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {23'd0, out_sel, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_sel", {31'd0, out_sel}, {31'd0, e.sel});
                chk("out_data", {24'd0, out_data}, {24'd0, e.data});
            end
        end
    end

    // One cycle of stimulus with hand-computed readies; accepted payloads are queued.
    task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic ordy, input logic e0,
                       input logic e1);
        exp_t e;
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        if (e0) begin
            e.sel = 1'b0; e.data = d0; exp_q.push_back(e);
        end
        if (e1) begin
            e.sel = 1'b1; e.data = d1; exp_q.push_back(e);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_out_sel"}, {31'd0, out_sel}, 32'd0);
        chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
    endtask

    initial begin
        // Initial reset: readies held low even with both valid and the slot empty.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready  = 1'b1;
        #12;
        chk_reset_outputs("rst0");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Contention right after reset: req0 first, then strict alternation.
        cyc(1, 8'hA0, 1, 8'hB1, 1, 1, 0);
        cyc(1, 8'hA0, 1, 8'hB1, 1, 0, 1);
        cyc(1, 8'hA0, 1, 8'hB1, 1, 1, 0);
        cyc(1, 8'hA0, 1, 8'hB1, 1, 0, 1);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

        // Single source back-to-back.
        cyc(1, 8'h11, 0, 8'h00, 1, 1, 0);
        cyc(1, 8'h22, 0, 8'h00, 1, 1, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

        // Backpressure: slot empty so 0x5C loads despite out_ready=0, then holds.
        cyc(0, 8'h00, 1, 8'h5C, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'h44, 1, 8'h55, 0, 0, 0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", {24'd0, out_data}, 32'h5C);
        end
        cyc(1, 8'h44, 1, 8'h55, 1, 1, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

        // Idle cycles leave priority untouched: after req1 wins, req0 goes next.
        cyc(0, 8'h00, 1, 8'h33, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        cyc(1, 8'h66, 1, 8'h77, 1, 1, 0);
        cyc(1, 8'h68, 1, 8'h77, 1, 0, 1);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

        // Mid-stream reset while req1 streams and the slot holds 0x82.
        cyc(0, 8'h00, 1, 8'h81, 1, 0, 1);
        cyc(0, 8'h00, 1, 8'h82, 1, 0, 1);
        @(posedge clk);
        #2;
        req0_valid = 1'b1;
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_out_data", {24'd0, out_data}, 32'h82);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst1");
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 8'h91, 1, 8'h92, 1, 1, 0);
        cyc(1, 8'h93, 1, 8'h92, 1, 0, 1);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

        chk("queue_drained", exp_q.size(), 32'd0);
        chk("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
